hazard_scoreboard: RTL and testbench

//   Next-generation pipeline hazard unit for the 5-stage core, extended for multi-cycle units (MUL/DIV).

---
 rtl/hazard_scoreboard.sv | 186 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the 5-stage core with multi-cycle (MUL/DIV) support.
//   - Forwarding from M / W into the execute stage operands.
//   - Load-use and branch-compare stalls.
//   - Per-register pending-write scoreboard for long-latency results (RAW and
//     WAW against decode), plus a structural stall when the long unit cannot
//     take a new op.
//   - A taken branch resolved in E wins over any stall: it clears IF/ID and
//     bubbles ID/EX instead of holding the front end.
//
// Optional feature macro: HAZARD_PERF_EN
//   defined   : StallCount / FlushCount are saturating cycle counters of
//               StallD / FlushD, cleared by rst.
//   undefined : no counter flops; both outputs tied to zero.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   Rs1D, Rs2D, RdD               decode-stage source/dest tags
//   RegWriteD, BranchD, LongOpD   decode-stage instruction attributes
//   Rs1E, Rs2E, RdE               execute-stage tags
//   RegWriteE, ResultSrcE         execute write enable, result source (01=load)
//   LongOpE                       execute instruction issues to long unit now
//   PCSrcE                        taken branch/jump resolved in E
//   RdM, RdW, RegWriteM/W         memory / writeback dest tags and enables
//   ResultSrcM                    memory-stage result source (01=load)
//   LongBusy                      long unit cannot accept a new op
//   LongDoneValid, LongDoneRd     long unit writes LongDoneRd to the RF now
//   ForwardAE, ForwardBE          00 RF, 10 from M, 01 from W
//   StallF, StallD                hold PC / IF-ID register
//   FlushE, FlushD                bubble ID-EX / clear IF-ID
//   StallCount, FlushCount        performance counters
//
// Handshake note: LongOpE is a single-cycle issue strobe (the long unit is
// assumed to accept whenever it is asserted, since structural stalls keep a
// busy unit from ever seeing it) and LongDoneValid is a single-cycle
// completion strobe with LongDoneRd valid in the same cycle; neither has a
// ready/back-pressure path into this block.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic                  BranchD,
  input  logic                  LongOpD,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  LongOpE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcM,
  input  logic                  LongBusy,
  input  logic                  LongDoneValid,
  input  logic [REG_ADDR_W-1:0] LongDoneRd,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushE,
  output logic                  FlushD,
  output logic [PERF_W-1:0]     StallCount,
  output logic [PERF_W-1:0]     FlushCount
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ZERO_TAG = '0;
  localparam logic [1:0] SRC_LOAD = 2'b01;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Clear first, then set, so an issue and a completion on the same tag in the
  // same cycle leave the entry pending (the new writer is still outstanding).
  // Entry 0 is hard-wired clear because x0 is never written.
  always_comb begin
    pending_next = pending;
    if (LongDoneValid)
      pending_next[LongDoneRd] = 1'b0;
    if (LongOpE && (RdE != ZERO_TAG))
      pending_next[RdE] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_next;
  end

  // ---------------------------------------------------------------------------
  // Forwarding into E (M has priority over W; x0 is never forwarded)
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != ZERO_TAG) begin
      if (RegWriteM && (RdM == rs))
        sel = 2'b10;
      else if (RegWriteW && (RdW == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E);
  assign ForwardBE = fwd_sel(Rs2E);

  // ---------------------------------------------------------------------------
  // Stall sources
  // ---------------------------------------------------------------------------
  // True when a non-zero producer tag matches either decode source.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rd);
    return (rd != ZERO_TAG) && ((rd == Rs1D) || (rd == Rs2D));
  endfunction

  logic lw_stall;
  logic br_stall;
  logic sb_raw;
  logic sb_waw;
  logic sb_stall;
  logic struct_stall;
  logic any_stall;

  assign lw_stall     = (ResultSrcE == SRC_LOAD) && src_match(RdE);
  assign br_stall     = BranchD &&
                        ((RegWriteE && src_match(RdE)) ||
                         ((ResultSrcM == SRC_LOAD) && src_match(RdM)));
  // pending[0] is always clear, so x0 sources never stall here.
  assign sb_raw       = pending[Rs1D] || pending[Rs2D];
  assign sb_waw       = RegWriteD && pending[RdD];
  assign sb_stall     = sb_raw || sb_waw;
  // An op entering the long unit from E this cycle occupies it as well.
  assign struct_stall = LongOpD && (LongBusy || LongOpE);
  assign any_stall    = lw_stall || br_stall || sb_stall || struct_stall;

  // A taken branch squashes the decode instruction, so holding it would be
  // pointless; the front end redirects instead. The op in E (possibly a long
  // op that already set its scoreboard bit) is older and is not touched.
  assign StallF = any_stall && !PCSrcE;
  assign StallD = any_stall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = any_stall || PCSrcE;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_count;
  logic [PERF_W-1:0] flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (StallD && (stall_count != {PERF_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (FlushD && (flush_count != {PERF_W{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign StallCount = stall_count;
  assign FlushCount = flush_count;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed scenarios followed by random traffic, compared every cycle with a
//   behavioural model (pending set as a bit array, hazard rules evaluated
//   directly from tag comparisons).
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int PW = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
  logic          RegWriteD, BranchD, LongOpD, RegWriteE, LongOpE, PCSrcE;
  logic          RegWriteM, RegWriteW, LongBusy, LongDoneValid;
  logic [1:0]    ResultSrcE, ResultSrcM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushE, FlushD;
  logic [PW-1:0] StallCount, FlushCount;

  hazard_scoreboard #(.REG_ADDR_W(AW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .BranchD(BranchD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .LongOpE(LongOpE),
    .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcM(ResultSrcM),
    .LongBusy(LongBusy), .LongDoneValid(LongDoneValid), .LongDoneRd(LongDoneRd),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping and reference model
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  bit          m_pend [32];
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [AW-1:0] rd);
    return (rd != 0) && (rd == Rs1D || rd == Rs2D);
  endfunction

  function automatic bit m_any_stall();
    bit lw, br, sb, st;
    lw = (ResultSrcE == 2'b01) && reads(RdE);
    br = BranchD && ((RegWriteE && reads(RdE)) || (ResultSrcM == 2'b01 && reads(RdM)));
    sb = m_pend[Rs1D] || m_pend[Rs2D] || (RegWriteD && m_pend[RdD]);
    st = LongOpD && (LongBusy || LongOpE);
    return lw || br || sb || st;
  endfunction

  task automatic check_all(input string tag);
    bit s;
    s = m_any_stall();
    chk({tag, ":fwdA"}, 32'(ForwardAE), 32'(m_fwd(Rs1E)));
    chk({tag, ":fwdB"}, 32'(ForwardBE), 32'(m_fwd(Rs2E)));
    chk({tag, ":stallF"}, 32'(StallF), 32'(s && !PCSrcE));
    chk({tag, ":stallD"}, 32'(StallD), 32'(s && !PCSrcE));
    chk({tag, ":flushE"}, 32'(FlushE), 32'(s || PCSrcE));
    chk({tag, ":flushD"}, 32'(FlushD), 32'(PCSrcE));
`ifdef HAZARD_PERF_EN
    chk({tag, ":stall_cnt"}, StallCount, m_stall_cnt);
    chk({tag, ":flush_cnt"}, FlushCount, m_flush_cnt);
`else
    chk({tag, ":stall_cnt"}, StallCount, 32'd0);
    chk({tag, ":flush_cnt"}, FlushCount, 32'd0);
`endif
  endtask

  // Advance one clock: model the edge from the inputs held during this cycle.
  task automatic model_edge();
    bit s;
    bit set_hit, clr_hit;
    s = m_any_stall();
    if (s && !PCSrcE && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (PCSrcE && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    for (int r = 1; r < 32; r++) begin
      set_hit = LongOpE && (RdE == AW'(r));
      clr_hit = LongDoneValid && (LongDoneRd == AW'(r));
      if (set_hit) m_pend[r] = 1'b1;
      else if (clr_hit) m_pend[r] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change at negedge, outputs sampled 4 ns later)
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; BranchD = 0; LongOpD = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0; RegWriteE = 0; ResultSrcE = 0; LongOpE = 0;
    PCSrcE = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcM = 0;
    LongBusy = 0; LongDoneValid = 0; LongDoneRd = 0;
  endtask

  task automatic step(input string tag);
    #4;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7));
    RdD  = AW'($urandom_range(0, 7));
    RegWriteD = 1'($urandom_range(0, 1)); BranchD = ($urandom_range(0, 3) == 0);
    LongOpD = ($urandom_range(0, 3) == 0);
    Rs1E = AW'($urandom_range(0, 7)); Rs2E = AW'($urandom_range(0, 7));
    RdE  = AW'($urandom_range(0, 7));
    RegWriteE = 1'($urandom_range(0, 1)); ResultSrcE = 2'($urandom_range(0, 3));
    LongOpE = ($urandom_range(0, 3) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
    RdM = AW'($urandom_range(0, 7)); RdW = AW'($urandom_range(0, 7));
    RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
    ResultSrcM = 2'($urandom_range(0, 3));
    LongBusy = ($urandom_range(0, 3) == 0);
    LongDoneValid = ($urandom_range(0, 2) == 0);
    LongDoneRd = AW'($urandom_range(0, 7));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    #4;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Forwarding: M wins over W; x0 operand never forwarded.
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    #1 chk("fwd_m_prio", 32'(ForwardAE), 32'd2);
    chk("fwd_x0", 32'(ForwardBE), 32'd0);
    #0 step("fwd");
    set_idle(); RdW = 6; RegWriteW = 1; Rs2E = 6; RdM = 6; RegWriteM = 0;
    step("fwd_w");

    // Load-use stall and the x0 non-match case.
    set_idle(); ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    #1 chk("lw_stall", 32'({StallF, StallD, FlushE}), 32'd7);
    #0 step("lw");
    set_idle(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    step("lw_x0");
    set_idle(); BranchD = 1; RegWriteE = 1; RdE = 2; Rs1D = 2;
    step("br_e");
    set_idle(); BranchD = 1; ResultSrcM = 2'b01; RdM = 4; Rs2D = 4;
    step("br_m");

    // Long op RAW: visible one cycle after issue, clears the cycle after done.
    set_idle(); LongOpE = 1; RdE = 7; Rs1D = 7;
    #1 chk("sb_issue_cycle", 32'(StallD), 32'd0);
    #0 step("sb_issue");
    set_idle(); Rs1D = 7;
    #1 chk("sb_raw", 32'(StallD), 32'd1);
    #0 step("sb_wait1");
    set_idle(); Rs1D = 7; step("sb_wait2");
    set_idle(); Rs1D = 7; LongDoneValid = 1; LongDoneRd = 7;
    step("sb_done");
    set_idle(); Rs1D = 7;
    #1 chk("sb_released", 32'(StallD), 32'd0);
    #0 step("sb_after");

    // WAW and set-wins on a same-tag issue + completion.
    set_idle(); LongOpE = 1; RdE = 9; step("waw_issue");
    set_idle(); RegWriteD = 1; RdD = 9; Rs1D = 1; Rs2D = 1;
    LongOpE = 1; RdE = 9; LongDoneValid = 1; LongDoneRd = 9;
    #1 chk("waw", 32'(StallD), 32'd1);
    #0 step("waw_setclr");
    set_idle(); RegWriteD = 1; RdD = 9;
    #1 chk("set_wins", 32'(StallD), 32'd1);
    #0 step("waw_hold");
    set_idle(); LongDoneValid = 1; LongDoneRd = 9; step("waw_done");
    set_idle(); LongDoneValid = 1; LongDoneRd = 12; step("clr_nonpending");

    // Structural stall.
    set_idle(); LongOpD = 1; LongBusy = 1; step("struct_busy");
    set_idle(); LongOpD = 1; LongOpE = 1; RdE = 0; step("struct_issue");

    // Taken branch overrides a stall.
    set_idle(); ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1;
    #1 chk("pcsrc_override", 32'({StallF, StallD, FlushD, FlushE}), 32'b0011);
    #0 step("pcsrc");

    // Async reset mid-cycle with an entry pending.
    set_idle(); LongOpE = 1; RdE = 4; step("rst_issue");
    set_idle(); Rs1D = 4;
    #1 chk("rst_pre", 32'(StallD), 32'd1);
    rst = 1'b1;
    #1 model_reset();
    chk("rst_async_stall", 32'(StallD), 32'd0);
    chk("rst_async_scnt", StallCount, 32'd0);
    chk("rst_async_fcnt", FlushCount, 32'd0);
    rst = 1'b0;
    step("rst_after");
    set_idle(); LongDoneValid = 1; LongDoneRd = 4; step("late_done");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
